// File: rtl/aircon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aircon_pkg                                                   |
// | Description : Shared widths, field tags, FSM states and word formatting    |
// |               for the air-conditioner status reporter.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aircon_pkg;

    localparam int FIELD_W    = 5;
    localparam int NUM_FIELDS = 4;
    localparam int SNAP_W     = FIELD_W * NUM_FIELDS;
    localparam int IDX_W      = 2;

    localparam logic [IDX_W-1:0] TAG_TEMP  = 2'd0;
    localparam logic [IDX_W-1:0] TAG_CAP   = 2'd1;
    localparam logic [IDX_W-1:0] TAG_FAN   = 2'd2;
    localparam logic [IDX_W-1:0] TAG_TIMER = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Stream word: tag, last-word flag, then the field taken from the snapshot.
    function automatic logic [7:0] make_word(input logic [IDX_W-1:0] idx,
                                             input logic [SNAP_W-1:0] snap);
        return {idx, (idx == TAG_TIMER), snap[int'(idx)*FIELD_W +: FIELD_W]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aircon_refresh_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aircon_refresh_tick                                          |
// | Description : Periodic one-cycle refresh pulse while power is on.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aircon_refresh_tick #(
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr,
    output logic tick
);

    localparam int               CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic             ENABLED = (REFRESH_CYCLES != 0);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    // Held at zero while unpowered so the first pulse lands a full period after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!pwr || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = ENABLED & pwr & w_at_last;

endmodule
`default_nettype wire

// File: rtl/aircon_status_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aircon_status_tx                                             |
// | Description : Snapshots the four settings and streams them as a 4-word     |
// |               valid/ready frame on request or periodic refresh.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aircon_status_tx
    import aircon_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwr,
    input  logic [4:0]   temp,
    input  logic [4:0]   cap,
    input  logic [4:0]   fan,
    input  logic [4:0]   timer,
    input  logic         req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         busy,
    output logic [7:0]   frame_count
);

    state_t              r_state;
    logic [SNAP_W-1:0]   r_snap;
    logic [IDX_W-1:0]    r_idx;
    logic                r_pending;

    logic                w_tick;
    logic                w_trigger;
    logic [SNAP_W-1:0]   w_live;

    aircon_refresh_tick #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .pwr  (pwr),
        .tick (w_tick)
    );

    assign w_trigger = (req | w_tick) & pwr;
    assign w_live    = {timer, fan, cap, temp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_snap      <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state   <= SEND;
                        r_snap    <= w_live;
                        r_idx     <= TAG_TEMP;
                        r_pending <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_data  <= make_word(TAG_TEMP, w_live);
                    end
                end

                SEND: begin
                    if (!pwr) begin
                        // Power loss abandons the frame and any queued request.
                        r_state   <= IDLE;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_data  <= '0;
                    end else if (out_ready) begin
                        if (r_idx == TAG_TIMER) begin
                            frame_count <= frame_count + 8'd1;
                            if (r_pending || w_trigger) begin
                                r_snap    <= w_live;
                                r_idx     <= TAG_TEMP;
                                r_pending <= 1'b0;
                                out_data  <= make_word(TAG_TEMP, w_live);
                            end else begin
                                r_state   <= IDLE;
                                r_idx     <= '0;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                out_data  <= '0;
                            end
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            r_pending <= r_pending | w_trigger;
                            out_data  <= make_word(r_idx + 2'd1, r_snap);
                        end
                    end else begin
                        r_pending <= r_pending | w_trigger;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aircon_status_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_aircon_status_tx                                          |
// | Description : Self-checking bench for aircon_status_tx.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aircon_status_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Request-driven instance (auto-report disabled).
    logic       rst, pwr, req, out_ready;
    logic [4:0] temp, cap, fan, timer;
    logic       out_valid, busy;
    logic [7:0] out_data, frame_count;

    // Auto-report instance with a short refresh period.
    logic       rst_r, pwr_r, req_r, ready_r;
    logic [4:0] temp_r, cap_r, fan_r, timer_r;
    logic       out_valid_r, busy_r;
    logic [7:0] out_data_r, frame_count_r;

    aircon_status_tx #(.REFRESH_CYCLES(0)) dut (
        .clk (clk), .rst (rst), .pwr (pwr),
        .temp (temp), .cap (cap), .fan (fan), .timer (timer),
        .req (req), .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .busy (busy), .frame_count (frame_count)
    );

    aircon_status_tx #(.REFRESH_CYCLES(8)) dut_r (
        .clk (clk), .rst (rst_r), .pwr (pwr_r),
        .temp (temp_r), .cap (cap_r), .fan (fan_r), .timer (timer_r),
        .req (req_r), .out_valid (out_valid_r), .out_ready (ready_r),
        .out_data (out_data_r), .busy (busy_r), .frame_count (frame_count_r)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [4:0]  temp, cap, fan, timer;
        logic [31:0] words;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] word(input logic [1:0] tag, input logic [4:0] val);
        return {tag, (tag == 2'd3), val};
    endfunction

    task automatic push_frame(input logic [4:0] t, input logic [4:0] c,
                              input logic [4:0] f, input logic [4:0] m);
        exp_q.push_back(word(2'd0, t));
        exp_q.push_back(word(2'd1, c));
        exp_q.push_back(word(2'd2, f));
        exp_q.push_back(word(2'd3, m));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                check("stream_word", out_data, exp_q.pop_front());
            end
            check("busy_eq_valid", busy, out_valid);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        vec_t v;

        vecs[0] = '{temp: 5'd22, cap: 5'd3,  fan: 5'd5,  timer: 5'd17, words: 32'h164385F1};
        vecs[1] = '{temp: 5'd0,  cap: 5'd0,  fan: 5'd0,  timer: 5'd0,  words: 32'h004080E0};
        vecs[2] = '{temp: 5'd31, cap: 5'd31, fan: 5'd31, timer: 5'd31, words: 32'h1F5F9FFF};
        vecs[3] = '{temp: 5'd10, cap: 5'd21, fan: 5'd7,  timer: 5'd1,  words: 32'h0A5587E1};

        rst = 1'b1; pwr = 1'b1; req = 1'b0; out_ready = 1'b1;
        temp = '0; cap = '0; fan = '0; timer = '0;
        rst_r = 1'b1; pwr_r = 1'b0; req_r = 1'b0; ready_r = 1'b1;
        temp_r = 5'd9; cap_r = 5'd4; fan_r = 5'd2; timer_r = 5'd30;

        step(); step();
        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_count", frame_count, 8'd0);
        rst = 1'b0; rst_r = 1'b0;
        step();

        // Single-request frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            temp = v.temp; cap = v.cap; fan = v.fan; timer = v.timer;
            exp_q.push_back(v.words[31:24]);
            exp_q.push_back(v.words[23:16]);
            exp_q.push_back(v.words[15:8]);
            exp_q.push_back(v.words[7:0]);
            req = 1'b1;
            step();
            req = 1'b0;
            check("trigger_latency", out_valid, 1'b1);
            drain(n);
            check("frame_cycles", n, 4);
            check("idle_after_frame", out_valid, 1'b0);
            check("frame_count", frame_count, i + 1);
            step();
        end

        // Backpressure on word 1 with a settings change mid-frame.
        temp = 5'd22; cap = 5'd3; fan = 5'd5; timer = 5'd17;
        push_frame(5'd22, 5'd3, 5'd5, 5'd17);
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        out_ready = 1'b0;
        cap = 5'd2;
        for (int k = 0; k < 5; k++) begin
            check("hold_data", out_data, 8'h43);
            check("hold_valid", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        drain(n);
        check("count_after_hold", frame_count, 8'd5);
        cap = 5'd3;
        step();

        // Requests during words 2 and 3 collapse into one back-to-back frame.
        push_frame(5'd22, 5'd3, 5'd5, 5'd17);
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        req = 1'b1;
        temp = 5'd1; cap = 5'd2; fan = 5'd3; timer = 5'd4;
        push_frame(5'd1, 5'd2, 5'd3, 5'd4);
        step();
        step();
        req = 1'b0;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_word0", out_data, 8'h01);
        drain(n);
        check("b2b_cycles", n, 4);
        for (int k = 0; k < 3; k++) begin
            check("no_extra_frame", out_valid, 1'b0);
            step();
        end
        check("count_after_b2b", frame_count, 8'd7);

        // Power drop while word 1 waits for the consumer.
        exp_q.push_back(8'h01);
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        out_ready = 1'b0;
        pwr = 1'b0;
        step();
        check("pwroff_valid", out_valid, 1'b0);
        check("pwroff_busy", busy, 1'b0);
        check("pwroff_count", frame_count, 8'd7);
        req = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("pwroff_req_ignored", out_valid, 1'b0);
        end
        req = 1'b0;
        pwr = 1'b1;
        step();
        check("pwroff_no_resume", out_valid, 1'b0);
        check("pwroff_queue", exp_q.size(), 0);

        // Asynchronous reset between edges, mid-frame.
        req = 1'b1;
        step();
        req = 1'b0;
        check("prereset_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_count", frame_count, 8'd0);
        check("async_rst_data", out_data, 8'h00);
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        temp = 5'd22; cap = 5'd3; fan = 5'd5; timer = 5'd17;
        step();
        push_frame(5'd22, 5'd3, 5'd5, 5'd17);
        req = 1'b1;
        step();
        req = 1'b0;
        check("post_reset_word0", out_data, 8'h16);
        drain(n);
        check("post_reset_count", frame_count, 8'd1);

        // Auto-report: frame k triggers at edge 8k and completes at edge 8k+4.
        pwr_r = 1'b1;
        for (int c = 1; c <= 2053; c++) begin
            step();
            if (c == 1)  check("auto_count_start", frame_count_r, 8'd0);
            if (c == 7)  check("auto_before_tick", out_valid_r, 1'b0);
            if (c == 8)  check("auto_first_word", out_data_r, 8'h09);
            if (c == 11) check("auto_last_word", out_data_r, 8'hFE);
            if (c == 12) check("auto_idle", out_valid_r, 1'b0);
            if (c == 12) check("auto_count_1", frame_count_r, 8'd1);
            if (c <= 64 && (c % 8) == 0) check("auto_period", out_valid_r, 1'b1);
            if (c <= 64 && (c % 8) == 4) check("auto_gap", out_valid_r, 1'b0);
            if (c == 2051) check("auto_count_255", frame_count_r, 8'd255);
            if (c == 2052) check("auto_count_wrap", frame_count_r, 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aircon_status_tx.md
# aircon_status_tx

Status reporter for the air-conditioner settings path: snapshots the four stored 5-bit settings (temperature, capacity, fan speed, timer) and transmits them as a 4-word frame over a valid/ready stream to the display/telemetry side. It is the read-out counterpart of the settings-write logic. Frames start on an explicit request or on a periodic refresh tick, and only while power is on.

## Interface
- REFRESH_CYCLES, default 1000: auto-report period in clocks; 0 disables auto-report.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pwr  in  1  unit power; 0 = off.
- temp  in  5  stored temperature setting.
- cap  in  5  stored capacity setting.
- fan  in  5  stored fan-speed setting.
- timer  in  5  stored timer setting.
- req  in  1  report request, sampled each clock.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_data  out  8  [7:6] field tag, [5] last-word flag, [4:0] field value.
- busy  out  1  high while a frame is in progress (state SEND).
- frame_count  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- Trigger = (req | refresh_tick) & pwr.
- States: IDLE, SEND.
- IDLE: out_valid=0. On trigger, capture {timer, fan, cap, temp} into a 20-bit snapshot, idx=0, go to SEND.
- SEND: out_valid=1, out_data = {idx, idx==3, snap[idx]}. Tag order: 0 temp, 1 cap, 2 fan, 3 timer.
  - On out_valid & out_ready with idx<3: idx++.
  - On out_valid & out_ready with idx==3: frame_count++.
    - If pending & pwr: re-capture the snapshot at this edge, clear pending, idx=0, stay in SEND.
    - Otherwise go to IDLE.
- Trigger while in SEND sets pending, a one-deep flag. Multiple triggers collapse into one. No trigger is lost except through power-off.
- Snapshot isolation: changes to temp/cap/fan/timer during a frame do not affect words of that frame.
- Power-off (pwr=0 sampled in SEND): abort. Next cycle out_valid=0, state IDLE, pending cleared, idx=0, frame_count unchanged. This is the only case where out_valid drops without a handshake.
- Refresh timer:
  - Counts clocks while pwr=1 and emits a 1-cycle refresh_tick when the count reaches REFRESH_CYCLES-1, then restarts at 0.
  - Held at 0 while pwr=0.
  - Free-runs regardless of busy; ticks during SEND set pending.

## Timing
- Reset values:
  - out_valid=0, out_data=0, busy=0, frame_count=0.
  - State IDLE; pending, idx and refresh count all 0.
- Trigger sampled at edge k: out_valid=1 with word 0 from edge k (visible in cycle k+1).
- With out_ready held high, the frame occupies 4 consecutive cycles. The following frame starts one cycle after IDLE re-entry, or is back-to-back (no bubble) if pending.
- While out_valid=1 and out_ready=0, out_data is stable.
- busy equals out_valid.
- frame_count updates on the edge that accepts word 3.
- First refresh_tick occurs REFRESH_CYCLES clocks after pwr rises.
- Simultaneous req and refresh_tick: one trigger.
- Trigger on the same edge as word-3 acceptance: treated as pending, so back-to-back frame.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package aircon_pkg:
  - FIELD_W=5, NUM_FIELDS=4.
  - Tag constants TAG_TEMP=2'd0, TAG_CAP=2'd1, TAG_FAN=2'd2, TAG_TIMER=2'd3.
  - State enum {IDLE, SEND}.
- One sub-module, aircon_refresh_tick: parameter REFRESH_CYCLES; inputs clk, rst, pwr; output tick. Counter width is $clog2(REFRESH_CYCLES), minimum 1.
- FSM, snapshot register, idx and pending live in the top module.

## Test plan
- Settings temp=22, cap=3, fan=5, timer=17, pwr=1, ready=1, 1-cycle req -> words 0x16, 0x43, 0x85, 0xF1 in four consecutive cycles; frame_count=1.
- Hold ready=0 for 5 cycles on word 1, change cap to 2 mid-frame -> out_data stays 0x43 throughout; snapshot value is sent.
- req during word 2, then req again during word 3 -> exactly one extra frame, no bubble after word 3; frame_count=2.
- pwr drops while word 1 is pending -> out_valid=0 next cycle; frame_count unchanged; no further words; req ignored while pwr=0.
- REFRESH_CYCLES=8, pwr raised, req never asserted -> frames start every 8 clocks once prior frames complete; frame_count increments per frame; wraps 255 -> 0.
- rst asserted mid-frame (async, between edges) -> out_valid, busy and frame_count read 0 immediately; first post-reset req yields a clean frame starting with tag 0.
